window_stream_ctrl: RTL and testbench

Sequencing controller for the 3x3 sliding-window filter pipeline. It tracks the raster position of the incoming pixel stream and frames each image between start and done. It also produces the window-valid strobe and delays it through its own internal delay line, so downstream logic sees `out_valid_o` aligned with the filter datapath output. It sits beside the line buffers and window delay registers and drives no pixel data itself.

---
 rtl/window_stream_ctrl.sv | 108 ++++++++++
 tb/tb_window_stream_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/window_stream_ctrl.sv
// Raster-position tracker and frame sequencer for the 3x3 window filter.
// Emits the window-valid strobe plus a copy delayed to line up with the datapath output.
module window_stream_ctrl #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int LATENCY = 5,
   parameter int COL_W   = $clog2(IMG_W),
   parameter int ROW_W   = $clog2(IMG_H)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             valid_i,
   output logic             busy_o,
   output logic [COL_W-1:0] col_o,
   output logic [ROW_W-1:0] row_o,
   output logic             win_valid_o,
   output logic             out_valid_o,
   output logic             done_o,
   output logic             ovf_o
);

   localparam int CNT_W = $clog2(LATENCY + 1);

   // Handshake: valid_i has no ready; a pixel is taken on any RUN cycle with valid_i high.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             state_q;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [LATENCY-1:0] dly_q, dly_d;
   logic               win_q, done_q, ovf_q, busy_q;
   logic               at_last_col, last_px, win_px;

   always_comb begin
      at_last_col = (col_q == COL_W'(IMG_W - 1));
      last_px     = at_last_col && (row_q == ROW_W'(IMG_H - 1));
      win_px      = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      col_d       = at_last_col ? '0 : col_q + 1'b1;
      row_d       = row_q;
      if (at_last_col) row_d = last_px ? '0 : row_q + 1'b1;
      dly_d       = dly_q << 1;
      dly_d[0]    = win_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         cnt_q   <= '0;
         dly_q   <= '0;
         win_q   <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         dly_q  <= dly_d;
         win_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_RUN;
                  col_q   <= '0;
                  row_q   <= '0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (valid_i) begin
                  col_q <= col_d;
                  row_q <= row_d;
                  win_q <= win_px;
                  if (last_px) begin
                     state_q <= S_DRAIN;
                     cnt_q   <= CNT_W'(LATENCY);
                  end
               end
            end
            // The last window strobe needs LATENCY+1 cycles to leave the delay line.
            S_DRAIN: begin
               if (valid_i) ovf_q <= 1'b1;
               if (cnt_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign col_o       = col_q;
   assign row_o       = row_q;
   assign win_valid_o = win_q;
   assign out_valid_o = dly_q[LATENCY-1];
   assign done_o      = done_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Randomized bench for window_stream_ctrl against an edge-indexed frame model
// built from pixel counts, window coordinates and scheduled strobe times.
module tb_window_stream_ctrl;

   localparam int W = 5;
   localparam int H = 4;
   localparam int L = 3;
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);

   logic          clk, rst, start_i, valid_i;
   logic          busy_o, win_valid_o, out_valid_o, done_o, ovf_o;
   logic [CW-1:0] col_o;
   logic [RW-1:0] row_o;

   window_stream_ctrl #(.IMG_W(W), .IMG_H(H), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
      .busy_o(busy_o), .col_o(col_o), .row_o(row_o),
      .win_valid_o(win_valid_o), .out_valid_o(out_valid_o),
      .done_o(done_o), .ovf_o(ovf_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard and frame model: mode 0 idle, 1 running, 2 tail after last pixel
   int          n_cmp = 0;
   int          n_bad = 0;
   int          e = 0;
   int          mode = 0;
   int          n = 0;
   int          t_last = 0;
   int          t_start = 0;
   logic        ovf_m = 1'b0;
   logic        win_m = 1'b0;
   logic [31:0] exp_q[$];
   int          win_cnt = 0;
   int          first_win_e = -1;
   int          done_e = -1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
      end
   endtask

   task automatic model_edge(input logic st, input logic vl);
      int c, r;
      win_m = 1'b0;
      case (mode)
         0: if (st) begin
            mode = 1; n = 0; ovf_m = 1'b0; t_start = e;
            win_cnt = 0; first_win_e = -1; done_e = -1;
         end
         1: if (vl) begin
            c = n % W;
            r = n / W;
            if (r >= 2 && c >= 2) begin
               win_m = 1'b1;
               exp_q.push_back(32'(e + L));
            end
            n++;
            if (n == W * H) begin
               mode = 2; t_last = e;
            end
         end
         default: begin
            if (vl && e <= t_last + L + 1) ovf_m = 1'b1;
            if (e == t_last + L + 2) mode = 0;
         end
      endcase
   endtask

   task automatic check_outputs();
      int   np;
      logic exp_busy, exp_done, exp_out;
      np       = n % (W * H);
      exp_busy = (mode == 1) || (mode == 2 && e <= t_last + L);
      exp_done = (mode == 2) && (e == t_last + L + 1);
      exp_out  = 1'b0;
      if (exp_q.size() > 0 && exp_q[0] == 32'(e)) begin
         exp_out = 1'b1;
         void'(exp_q.pop_front());
      end
      check_eq("busy", 32'(busy_o), 32'(exp_busy));
      check_eq("col", 32'(col_o), 32'(np % W));
      check_eq("row", 32'(row_o), 32'(np / W));
      check_eq("win_valid", 32'(win_valid_o), 32'(win_m));
      check_eq("out_valid", 32'(out_valid_o), 32'(exp_out));
      check_eq("done", 32'(done_o), 32'(exp_done));
      check_eq("ovf", 32'(ovf_o), 32'(ovf_m));
      if (win_valid_o === 1'b1) begin
         win_cnt++;
         if (first_win_e < 0) first_win_e = e;
      end
      if (done_o === 1'b1) done_e = e;
      if (exp_done) check_eq("win_count", 32'(win_cnt), 32'((W - 2) * (H - 2)));
   endtask

   // driver tasks
   task automatic step(input logic st, input logic vl);
      start_i = st;
      valid_i = vl;
      @(posedge clk);
      e++;
      model_edge(st, vl);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check_eq("rst_busy", 32'(busy_o), 0);
      check_eq("rst_col", 32'(col_o), 0);
      check_eq("rst_row", 32'(row_o), 0);
      check_eq("rst_win", 32'(win_valid_o), 0);
      check_eq("rst_out", 32'(out_valid_o), 0);
      check_eq("rst_done", 32'(done_o), 0);
      check_eq("rst_ovf", 32'(ovf_o), 0);
      mode = 0; n = 0; ovf_m = 1'b0; win_m = 1'b0; win_cnt = 0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // pat: 0 dense, 1 toggling, 2 random; abort_px > 0 resets after that many pixels
   task automatic run_frame(input int pat, input logic tail_valid, input logic tail_start,
                            input int abort_px);
      int   guard, k;
      logic v;
      guard = 0;
      while (mode != 1 && guard < 20) begin
         step(1'b1, 1'($urandom_range(0, 1)));
         guard++;
      end
      if (mode != 1) check_eq("start_timeout", 0, 1);
      k = 0;
      guard = 0;
      while (mode == 1 && guard < 2000) begin
         if (abort_px > 0 && n >= abort_px) begin
            do_reset();
            return;
         end
         case (pat)
            0:       v = 1'b1;
            1:       v = (k % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         step(1'($urandom_range(0, 3) == 0), v);
         k++;
         guard++;
      end
      if (mode == 1) check_eq("run_timeout", 0, 1);
      for (int i = 0; i < L + 2; i++)
         step(tail_start, tail_valid ? 1'b1 : 1'($urandom_range(0, 1)));
      check_eq("done_latency", 32'(done_e - t_last), 32'(L + 1));
      if (pat == 0) check_eq("first_win_latency", 32'(first_win_e - t_start), 13);
   endtask

   initial begin
      rst = 1'b1;
      start_i = 1'b0;
      valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_outputs();
      // nominal, gapped, overflow with start held through DONE
      run_frame(0, 1'b0, 1'b0, 0);
      repeat (3) step(1'b0, 1'b0);
      run_frame(1, 1'b0, 1'b0, 0);
      step(1'b0, 1'b1);
      run_frame(0, 1'b1, 1'b1, 0);
      repeat (4) step(1'b0, 1'($urandom_range(0, 1)));
      // abort at row 2, then idle long enough for any stale strobe to appear
      run_frame(0, 1'b0, 1'b0, 2 * W + 1);
      repeat (L + 3) step(1'b0, 1'b0);
      run_frame(0, 1'b0, 1'b0, 0);
      for (int f = 0; f < 8; f++) begin
         run_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
         repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
